// File: rtl/cache_refill_ctrl.sv
// Cache refill controller: serves read hits from the cache, refills missing lines from memory, writes through.
// Latency (mem_ready high): read hit 2, read miss 7, write miss 3, write hit 8 cycles; stalls on mem_ready with timeout abort.
module cache_refill_ctrl #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_ready,
  output logic                  cpu_err,
  output logic [ADDR_W-1:0]     cache_addr,
  output logic                  cache_re,
  input  logic                  cache_hit,
  input  logic [DATA_W-1:0]     cache_data,
  output logic                  cache_we,
  output logic [4*DATA_W-1:0]   cache_line,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITE_THRU, FILL, WRITE_LINE, RESPOND} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                is_wr;
  logic                hit_q;
  logic [1:0]          beat;
  logic [CNT_W-1:0]    tmo_cnt;
  logic [4*DATA_W-1:0] line_buf;
  logic                timed_out;
  logic                mem_wait;

  assign timed_out = (tmo_cnt == CNT_W'(TIMEOUT));
  assign mem_wait  = (state == WRITE_THRU) || (state == FILL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (cpu_wr || cpu_rd) state_nxt = LOOKUP;
      LOOKUP:     if (is_wr)          state_nxt = WRITE_THRU;
                  else if (cache_hit) state_nxt = RESPOND;
                  else                state_nxt = FILL;
      WRITE_THRU: if (timed_out)      state_nxt = IDLE;
                  else if (mem_ready) state_nxt = hit_q ? FILL : RESPOND;
      FILL:       if (timed_out)      state_nxt = IDLE;
                  else if (mem_ready && beat == 2'd3) state_nxt = WRITE_LINE;
      WRITE_LINE:                     state_nxt = RESPOND;
      RESPOND:                        state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // A timed-out wait state drops the memory request and reports completion with error in the same cycle.
  always_comb begin
    cpu_ready  = 1'b0;
    cpu_err    = 1'b0;
    cache_addr = '0;
    cache_re   = 1'b0;
    cache_we   = 1'b0;
    cache_line = '0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      LOOKUP: begin
        cache_re   = 1'b1;
        cache_addr = addr_q;
      end
      WRITE_THRU: begin
        if (timed_out) begin
          cpu_ready = 1'b1;
          cpu_err   = 1'b1;
        end else begin
          mem_wr    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end
      end
      FILL: begin
        if (timed_out) begin
          cpu_ready = 1'b1;
          cpu_err   = 1'b1;
        end else begin
          mem_rd   = 1'b1;
          mem_addr = {addr_q[ADDR_W-1:2], beat};
        end
      end
      WRITE_LINE: begin
        cache_we   = 1'b1;
        cache_addr = {addr_q[ADDR_W-1:2], 2'b00};
        cache_line = line_buf;
      end
      RESPOND: cpu_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      is_wr     <= 1'b0;
      hit_q     <= 1'b0;
      beat      <= '0;
      tmo_cnt   <= '0;
      line_buf  <= '0;
      cpu_rdata <= '0;
    end else begin
      if (mem_wait && !mem_ready && !timed_out) tmo_cnt <= tmo_cnt + CNT_W'(1);
      else                                      tmo_cnt <= '0;
      case (state)
        IDLE: begin
          if (cpu_wr || cpu_rd) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            is_wr   <= cpu_wr;
          end
        end
        LOOKUP: begin
          hit_q <= cache_hit;
          beat  <= '0;
          if (!is_wr && cache_hit) cpu_rdata <= cache_data;
        end
        WRITE_THRU: beat <= '0;
        FILL: begin
          if (mem_ready && !timed_out) begin
            line_buf[DATA_W*int'(beat) +: DATA_W] <= mem_rdata;
            beat <= beat + 2'd1;
          end
        end
        WRITE_LINE: begin
          if (!is_wr) cpu_rdata <= line_buf[DATA_W*int'(addr_q[1:0]) +: DATA_W];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: memory responder model, scoreboards for responses, line writes and memory writes.
module tb_cache_refill_ctrl;
  logic         clk, rst, cpu_rd, cpu_wr;
  logic [14:0]  cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_ready, cpu_err;
  logic [14:0]  cache_addr;
  logic         cache_re, cache_hit, cache_we;
  logic [31:0]  cache_data;
  logic [127:0] cache_line;
  logic         mem_rd, mem_wr, mem_ready;
  logic [14:0]  mem_addr;
  logic [31:0]  mem_wdata, mem_rdata;

  typedef struct {logic [31:0] rdata; logic err; int lat;} resp_t;
  typedef struct {logic [14:0] addr; logic [127:0] line;} line_t;
  typedef struct {logic [14:0] addr; logic [31:0] data;} mw_t;
  resp_t sb[$];
  line_t lq[$];
  mw_t   wq[$];

  int n_assert = 0, n_fail = 0, cyc = 0, t0 = 0;
  int n_mem_rd = 0, n_mem_wr = 0, n_we = 0, mem_delay = 0;
  bit mem_stuck = 0;
  logic [31:0] exp_rdata;
  logic [14:0] exp_look;

  cache_refill_ctrl #(.ADDR_W(15), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .cache_addr(cache_addr), .cache_re(cache_re), .cache_hit(cache_hit), .cache_data(cache_data),
    .cache_we(cache_we), .cache_line(cache_line), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] mem_val(input logic [14:0] a);
    logic [31:0] v;
    v = 32'h11 * ({30'd0, a[1:0]} + 32'd1);
    if (a[14:2] != 13'h1401) v = v ^ {1'b0, a, 16'h0};
    return v;
  endfunction

  function automatic logic [127:0] line_of(input logic [14:0] a);
    logic [14:0] b;
    b = {a[14:2], 2'b00};
    return {mem_val(b + 15'd3), mem_val(b + 15'd2), mem_val(b + 15'd1), mem_val(b)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_resp(input logic [31:0] d, input logic e, input int lat);
    resp_t r;
    r.rdata = d; r.err = e; r.lat = lat;
    sb.push_back(r);
  endtask

  task automatic push_line(input logic [14:0] a);
    line_t l;
    l.addr = {a[14:2], 2'b00}; l.line = line_of(a);
    lq.push_back(l);
  endtask

  task automatic push_mw(input logic [14:0] a, input logic [31:0] d);
    mw_t w;
    w.addr = a; w.data = d;
    wq.push_back(w);
  endtask

  task automatic request(input logic rd, input logic wr, input logic [14:0] a, input logic [31:0] d,
                         input logic hit, input logic [31:0] cdata);
    @(negedge clk);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    cache_hit = hit; cache_data = cdata;
    exp_look = a;
    t0 = cyc;
    @(negedge clk);
    cpu_rd = 0; cpu_wr = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("done_in_budget", sb.size() == 0, 1);
    check("lines_written", lq.size(), 0);
    check("mem_writes_done", wq.size(), 0);
  endtask

  // Memory model: answers after mem_delay wait cycles per beat, or never while stuck.
  initial begin
    int wcnt = 0;
    mem_ready = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      if ((mem_rd || mem_wr) && !mem_stuck) begin
        if (wcnt == mem_delay) begin
          mem_ready = 1; mem_rdata = mem_val(mem_addr); wcnt = 0;
        end else begin
          mem_ready = 0; wcnt++;
        end
      end else begin
        mem_ready = 0; wcnt = 0;
      end
    end
  end

  initial begin
    bit prev_wait = 0;
    logic [14:0] prev_addr = 0;
    resp_t r;
    line_t l;
    mw_t w;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        prev_wait = 0;
        continue;
      end
      if (mem_rd || mem_wr) check("rd_wr_exclusive", mem_rd & mem_wr, 0);
      if (mem_rd) n_mem_rd++;
      if (prev_wait && mem_rd) check("mem_addr_hold", mem_addr, prev_addr);
      prev_wait = mem_rd && !mem_ready;
      prev_addr = mem_addr;
      if (cache_re) check("lookup_addr", cache_addr, exp_look);
      if (mem_wr && mem_ready) begin
        n_mem_wr++;
        check("mw_expected", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          check("mem_wr_addr", mem_addr, w.addr);
          check("mem_wdata", mem_wdata, w.data);
        end
      end
      if (cache_we) begin
        n_we++;
        check("we_expected", lq.size() != 0, 1);
        if (lq.size() != 0) begin
          l = lq.pop_front();
          check("cache_we_addr", cache_addr, l.addr);
          check("cache_line", cache_line, l.line);
        end
      end
      if (cpu_ready) begin
        check("resp_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          r = sb.pop_front();
          check("cpu_rdata", cpu_rdata, r.rdata);
          check("cpu_err", cpu_err, r.err);
          check("latency", cyc - t0, r.lat);
          if (r.err) check("abort_drops_mem", {mem_rd, mem_wr}, 2'b00);
        end
      end else if (cpu_err) begin
        check("err_without_ready", cpu_err, 0);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0; cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    cache_hit = 0; cache_data = 0; exp_rdata = 0; exp_look = 0;
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", cpu_ready, 0);
    check("rst_cpu_err", cpu_err, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_cache_ctl", {cache_re, cache_we, mem_rd, mem_wr}, 4'b0);
    check("rst_cache_line", cache_line, 0);
    check("rst_mem_addr", mem_addr, 0);
    rst = 1;
    @(negedge clk);

    // read hit
    n_mem_rd = 0; n_we = 0;
    exp_rdata = 32'hDEADBEEF;
    push_resp(exp_rdata, 0, 2);
    request(1, 0, 15'h0005, 32'h0, 1, 32'hDEADBEEF);
    wait_idle(20);
    check("hit_no_mem_rd", n_mem_rd, 0);
    check("hit_no_we", n_we, 0);

    // read miss, immediate memory
    exp_rdata = 32'h33;
    push_line(15'h5006);
    push_resp(exp_rdata, 0, 7);
    request(1, 0, 15'h5006, 32'h0, 0, 32'hFFFFFFFF);
    wait_idle(30);

    // read miss, three wait cycles per beat
    mem_delay = 3; n_we = 0;
    push_line(15'h5006);
    push_resp(exp_rdata, 0, 19);
    request(1, 0, 15'h5006, 32'h0, 0, 32'hFFFFFFFF);
    wait_idle(40);
    check("slow_miss_one_we", n_we, 1);
    mem_delay = 0;

    // write hit: write-through then refill
    n_mem_rd = 0; n_we = 0;
    push_mw(15'h1234, 32'hCAFEF00D);
    push_line(15'h1234);
    push_resp(exp_rdata, 0, 8);
    request(0, 1, 15'h1234, 32'hCAFEF00D, 1, 32'h0);
    wait_idle(30);
    check("wr_hit_mem_rd_beats", n_mem_rd, 4);
    check("wr_hit_one_we", n_we, 1);

    // write miss
    n_mem_rd = 0; n_we = 0;
    push_mw(15'h0ABC, 32'h12345678);
    push_resp(exp_rdata, 0, 3);
    request(0, 1, 15'h0ABC, 32'h12345678, 0, 32'h0);
    wait_idle(30);
    check("wr_miss_no_mem_rd", n_mem_rd, 0);
    check("wr_miss_no_we", n_we, 0);

    // read and write together behave as a write
    n_mem_rd = 0;
    push_mw(15'h2222, 32'h0BADCAFE);
    push_resp(exp_rdata, 0, 3);
    request(1, 1, 15'h2222, 32'h0BADCAFE, 0, 32'h0);
    wait_idle(30);
    check("rdwr_no_mem_rd", n_mem_rd, 0);

    // requests arriving during a fill are ignored
    mem_delay = 3; n_mem_wr = 0;
    exp_rdata = mem_val(15'h3009);
    push_line(15'h3009);
    push_resp(exp_rdata, 0, 19);
    request(1, 0, 15'h3009, 32'h0, 0, 32'h0);
    repeat (2) @(negedge clk);
    cpu_rd = 1; cpu_wr = 1; cpu_addr = 15'h7777; cpu_wdata = 32'h55AA55AA;
    repeat (8) @(negedge clk);
    cpu_rd = 0; cpu_wr = 0;
    wait_idle(40);
    check("ignored_no_mem_wr", n_mem_wr, 0);
    mem_delay = 0;

    // memory never answers: timeout abort
    mem_stuck = 1; n_mem_rd = 0; n_we = 0;
    push_resp(exp_rdata, 1, 10);
    request(1, 0, 15'h0100, 32'h0, 0, 32'h0);
    wait_idle(40);
    check("timeout_wait_cycles", n_mem_rd, 8);
    check("timeout_no_we", n_we, 0);
    mem_stuck = 0;

    // reset in the middle of a fill
    mem_delay = 3; n_we = 0;
    request(1, 0, 15'h4000, 32'h0, 0, 32'h0);
    repeat (3) @(negedge clk);
    #1 rst = 0;
    #1;
    check("midrst_ready_err", {cpu_ready, cpu_err}, 2'b00);
    check("midrst_ctl", {cache_re, cache_we, mem_rd, mem_wr}, 4'b0);
    check("midrst_rdata", cpu_rdata, 0);
    check("midrst_mem_addr", mem_addr, 0);
    exp_rdata = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (25) @(negedge clk);
    check("midrst_no_we", n_we, 0);
    mem_delay = 0;

    // recovery after reset
    exp_rdata = 32'h600DF00D;
    push_resp(exp_rdata, 0, 2);
    request(1, 0, 15'h0FFF, 32'h0, 1, 32'h600DF00D);
    wait_idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Controller sitting between the CPU data port and the direct-mapped data cache: 1024 lines, 128-bit lines of four 32-bit words, 3-bit tag, 15-bit word address.
- Drives the cache's read/write side and performs line refills from main memory over a 32-bit word handshake.
- Writes are write-through, no-allocate.
- On a write hit, the line is refilled so the cache stays coherent.

Parameters:
ADDR_W, 15, word address width: tag [14:12], index [11:2], offset [1:0].
DATA_W, 32, word width; line width is 4*DATA_W.
TIMEOUT, 255, max cycles waiting for mem_ready on one beat before abort.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cpu_rd  in  1  read request, sampled in IDLE
cpu_wr  in  1  write request, sampled in IDLE; wins over cpu_rd
cpu_addr  in  15  request word address
cpu_wdata  in  32  write data
cpu_rdata  out  32  read data, valid with cpu_ready, held until next response
cpu_ready  out  1  one-cycle completion pulse
cpu_err  out  1  one-cycle pulse with cpu_ready on timeout abort
cache_addr  out  15  address to cache
cache_re  out  1  cache read enable
cache_hit  in  1  cache hit for cache_addr
cache_data  in  32  cache word output
cache_we  out  1  cache line write enable, one cycle
cache_line  out  128  line to write; word k at bits [32k+31:32k]
mem_rd  out  1  memory word read request
mem_wr  out  1  memory word write request
mem_addr  out  15  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid with mem_ready
mem_ready  in  1  memory beat complete

Behaviour:
Reset:
- rst low forces state IDLE and zeroes all outputs, cpu_rdata, the line buffer, the beat counter and the timeout counter.
- Reset mid-operation aborts it: no cache write, no cpu_ready.

IDLE:
- On cpu_wr or cpu_rd, latch cpu_addr and cpu_wdata, then go to LOOKUP.
- Requests are ignored outside IDLE.

LOOKUP (1 cycle):
- cache_re=1, cache_addr=latched address.
- cache_hit and cache_data are sampled at the end of the cycle.
- Read hit: cpu_rdata<=cache_data, go to RESPOND.
- Read miss: beat=0, go to FILL.
- Write (hit or miss): go to WRITE_THRU; the hit flag is recorded.

WRITE_THRU:
- mem_wr=1, mem_addr=latched address, mem_wdata=latched data, held until mem_ready.
- On mem_ready: if recorded hit, beat=0 and go to FILL; else go to RESPOND.

FILL:
- mem_rd=1, mem_addr={tag,index,beat}.
- On mem_ready: line buffer word[beat]<=mem_rdata, beat++.
- After beat 3 completes, go to WRITE_LINE.
- mem_rd may stay high across beats; the address changes after each accepted beat.

WRITE_LINE (1 cycle):
- cache_we=1, cache_addr={tag,index,2'b00}, cache_line=buffer.
- For a read, cpu_rdata<=buffer word[offset]; the cache is not re-read.
- Go to RESPOND.

RESPOND (1 cycle):
- cpu_ready=1, then IDLE.

Timeout:
- The counter resets on each mem_ready and on entry to WRITE_THRU/FILL.
- When it reaches TIMEOUT: drop mem_rd/mem_wr, pulse cpu_ready and cpu_err together.
- No cache write occurs, cpu_rdata is unchanged, go to IDLE.

Latency, from the accepting edge with mem_ready tied high:
- Read hit: cpu_ready in cycle 2.
- Read miss: cycle 7.
- Write miss: cycle 3.
- Write hit: cycle 8.

Other rules:
- cache_re, cache_we, mem_rd and mem_wr are never high outside their states.
- mem_rd and mem_wr are never high together.

Test Plan:
- Reset, then read 0x0005 with cache_hit=1, cache_data=0xDEADBEEF -> cpu_ready in cycle 2, cpu_rdata=0xDEADBEEF, no mem_rd.
- Read 0x5006 miss, memory returns 0x11,0x22,0x33,0x44 for addresses 0x5004..0x5007 -> one cache_we with cache_addr=0x5004, cache_line=0x00000044_00000033_00000022_00000011, cpu_rdata=0x33.
- Same miss with mem_ready delayed 3 cycles per beat -> mem_addr holds steady during each wait, cpu_ready in cycle 19.
- Write 0x1234 data 0xCAFEF00D, hit -> mem_wr at 0x1234 with that data, then refill of 0x1234..0x1237, cache_we once, cpu_ready; write miss -> no mem_rd, no cache_we.
- cpu_rd and cpu_wr high together -> treated as write. Requests during a fill -> ignored.
- mem_ready stuck low with TIMEOUT=8 -> cpu_ready and cpu_err pulse after 8 waiting cycles, no cache_we. Assert rst mid-FILL -> all outputs 0 immediately, no cpu_ready.
